mem_arbiter: RTL and testbench

Two-requester memory-port arbiter that shares one 128-bit line memory port between the instruction-cache refill path and the data cache. It serializes accesses so only one is outstanding at a time. It favours the data cache, with an anti-starvation override for instruction fetch. It drops instruction-refill responses that were made stale by a branch redirect. It sits between both cache controllers and the memory/bus interface.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_starve_counter.sv | 37 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ICACHE_LINE_WIDTH = 128;
  localparam int unsigned LINE_OFFS_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mem_arb_state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } mem_owner_t;

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating counter of consecutive cycles a pending icache request went ungranted.
module mem_arbiter_starve_counter #(
  parameter int unsigned LIMIT = 4,
  localparam int unsigned CW   = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_i,
  input  logic clear_i,
  output logic at_limit_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear has priority; increment saturates at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between icache refill and dcache, one access at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LINE_WIDTH   = ICACHE_LINE_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_req_valid,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  output logic                  ic_req_ready,
  input  logic                  ic_flush,
  output logic                  ic_resp_valid,
  output logic [LINE_WIDTH-1:0] ic_resp_data,
  input  logic                  dc_req_valid,
  input  logic                  dc_req_we,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [LINE_WIDTH-1:0] dc_req_wdata,
  output logic                  dc_req_ready,
  output logic                  dc_resp_valid,
  output logic [LINE_WIDTH-1:0] dc_resp_data,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data,
  output logic                  busy
);

  mem_arb_state_t        state_q;
  mem_arb_state_t        state_d;
  mem_owner_t            owner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] resp_data_q;
  logic                  drop_q;
  logic                  drop_d;
  logic                  ic_resp_valid_q;
  logic                  dc_resp_valid_q;

  logic grant_ic_c;
  logic grant_dc_c;
  logic starve_at_limit;
  logic resp_fire_c;
  logic drop_eff_c;
  logic unused_addr_bits;

  // Line offset bits of the request addresses are don't-care.
  assign unused_addr_bits = ^{ic_req_addr[LINE_OFFS_W-1:0], dc_req_addr[LINE_OFFS_W-1:0]};

  mem_arbiter_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .inc_i      (ic_req_valid && !grant_ic_c),
    .clear_i    (!ic_req_valid || grant_ic_c),
    .at_limit_o (starve_at_limit)
  );

  // Grant evaluation in IDLE: flush blocks icache, starvation beats dcache priority.
  always_comb begin
    grant_ic_c = 1'b0;
    grant_dc_c = 1'b0;
    if (state_q == IDLE) begin
      grant_ic_c = ic_req_valid && !ic_flush && (starve_at_limit || !dc_req_valid);
      grant_dc_c = dc_req_valid && !grant_ic_c;
    end
  end

  // Response completion and stale-refill tracking; a flush in the response cycle still drops.
  always_comb begin
    resp_fire_c = (state_q == WAIT) && mem_resp_valid;
    drop_eff_c  = drop_q || (ic_flush && (owner_q == OWNER_IC));
    drop_d      = (state_q != IDLE) && !resp_fire_c && drop_eff_c;
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ic_c || grant_dc_c) state_d = ISSUE;
      ISSUE:   if (mem_req_ready)            state_d = WAIT;
      WAIT:    if (mem_resp_valid)           state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // FSM outputs; accept strobes are only meaningful out of reset.
  always_comb begin
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        ic_req_ready = grant_ic_c && reset;
        dc_req_ready = grant_dc_c && reset;
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        busy          = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Latched request payload, drop flag and registered response pulses.
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q         <= OWNER_IC;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      resp_data_q     <= '0;
      drop_q          <= 1'b0;
      ic_resp_valid_q <= 1'b0;
      dc_resp_valid_q <= 1'b0;
    end else begin
      drop_q          <= drop_d;
      ic_resp_valid_q <= resp_fire_c && (owner_q == OWNER_IC) && !drop_eff_c;
      dc_resp_valid_q <= resp_fire_c && (owner_q == OWNER_DC);
      if (resp_fire_c) begin
        resp_data_q <= mem_resp_data;
      end
      if (grant_dc_c) begin
        owner_q <= OWNER_DC;
        we_q    <= dc_req_we;
        addr_q  <= {dc_req_addr[ADDR_WIDTH-1:LINE_OFFS_W], {LINE_OFFS_W{1'b0}}};
        wdata_q <= dc_req_wdata;
      end else if (grant_ic_c) begin
        owner_q <= OWNER_IC;
        we_q    <= 1'b0;
        addr_q  <= {ic_req_addr[ADDR_WIDTH-1:LINE_OFFS_W], {LINE_OFFS_W{1'b0}}};
        wdata_q <= '0;
      end
    end
  end

  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign dc_resp_valid = dc_resp_valid_q;
  assign ic_resp_data  = resp_data_q;
  assign dc_resp_data  = resp_data_q;

  // Memory must only answer an accepted request.
  a_resp_only_in_wait: assert property (
    @(posedge clock) disable iff (!reset) mem_resp_valid |-> (state_q == WAIT)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and arbitration model.
module tb_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned LW    = 128;
  localparam int unsigned LIMIT = 4;

  logic          clock;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_flush, ic_resp_valid;
  logic [AW-1:0] ic_req_addr;
  logic [LW-1:0] ic_resp_data;
  logic          dc_req_valid, dc_req_we, dc_req_ready, dc_resp_valid;
  logic [AW-1:0] dc_req_addr;
  logic [LW-1:0] dc_req_wdata, dc_resp_data;
  logic          mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid, busy;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata, mem_resp_data;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_flush(ic_flush), .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_ready(dc_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [LW-1:0] line_init(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, 32'h1234_5678};
  endfunction

  // ---------------- memory environment (independent storage) ----------------
  logic [LW-1:0] env_mem [logic [AW-1:0]];
  int            force_stall = -1;
  int            force_lat   = -1;

  initial begin
    int            e_state;
    int            e_stall;
    int            e_lat;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [LW-1:0] e_wdata;
    e_state = 0; e_stall = -1; e_lat = 0;
    e_addr = '0; e_we = 1'b0; e_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      @(posedge clock);
      #2;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (!reset) begin
        e_state = 0;
        e_stall = -1;
      end else if (e_state == 0) begin
        if (mem_req_valid) begin
          if (e_stall < 0) e_stall = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 2));
          if (e_stall == 0) begin
            mem_req_ready = 1'b1;
            e_addr  = mem_req_addr;
            e_we    = mem_req_we;
            e_wdata = mem_req_wdata;
            e_lat   = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
            e_stall = -1;
            e_state = 1;
          end else begin
            e_stall--;
          end
        end
      end else begin
        if (e_lat == 0) begin
          mem_resp_valid = 1'b1;
          if (e_we) begin
            env_mem[e_addr] = e_wdata;
            mem_resp_data   = {$urandom, $urandom, $urandom, $urandom};
          end else begin
            mem_resp_data = env_mem.exists(e_addr) ? env_mem[e_addr] : line_init(e_addr);
          end
          e_state = 0;
        end else begin
          e_lat--;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard producer ----------------
  typedef struct {
    bit            owner_dc;
    bit            is_read;
    logic [LW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];

  bit            m_busy = 0, m_acc = 0, m_drop = 0, m_owner_dc = 0, m_we = 0, rst_prev = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0, m_rdata = '0;
  int            m_starve = 0, ic_opp = 0, last_ic_opp = 0;
  int            last_ic_grant = 0, last_ic_pulse = 0, last_dc_pulse = 0;
  int            ic_pulses = 0, dc_pulses = 0;
  bit            ic_acc = 0, dc_acc = 0;

  always @(negedge clock) begin
    bit exp_ic, exp_dc, idle_now;
    ic_acc = ic_req_valid && ic_req_ready;
    dc_acc = dc_req_valid && dc_req_ready;
    if (rst_prev) begin
      check("rst_busy",      busy, 0);
      check("rst_mem_valid", mem_req_valid, 0);
      check("rst_mem_we",    mem_req_we, 0);
      check("rst_mem_addr",  mem_req_addr, 0);
      check("rst_mem_wdata", mem_req_wdata, 0);
      check("rst_resp",      {ic_resp_valid, dc_resp_valid}, 0);
      check("rst_resp_data", ic_resp_data, 0);
    end
    if (!reset) begin
      check("rst_ready", {ic_req_ready, dc_req_ready}, 0);
      m_busy = 0; m_acc = 0; m_drop = 0; m_starve = 0; ic_opp = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      idle_now = !m_busy;
      exp_ic = 0;
      exp_dc = 0;
      if (idle_now) begin
        exp_ic = ic_req_valid && !ic_flush && (m_starve == LIMIT || !dc_req_valid);
        exp_dc = dc_req_valid && !exp_ic;
      end
      check("ic_ready",  ic_req_ready, exp_ic);
      check("dc_ready",  dc_req_ready, exp_dc);
      check("busy",      busy, m_busy);
      check("mem_valid", mem_req_valid, m_busy && !m_acc);
      if (m_busy && !m_acc) begin
        check("mem_addr", mem_req_addr, m_addr);
        check("mem_we",   mem_req_we, m_we);
        if (m_we) check("mem_wdata", mem_req_wdata, m_wdata);
      end
      if (m_busy && !m_owner_dc && ic_flush) m_drop = 1;
      if (m_busy && m_acc && mem_resp_valid) begin
        if (!m_drop) exp_q.push_back('{m_owner_dc, !m_we, m_rdata, cyc + 1});
        m_busy = 0;
      end else if (m_busy && !m_acc && mem_req_ready) begin
        m_acc = 1;
      end
      if (!ic_req_valid) ic_opp = 0;
      else if (idle_now && !ic_flush) ic_opp++;
      if (exp_ic) begin
        last_ic_opp   = ic_opp;
        last_ic_grant = cyc;
        ic_opp        = 0;
      end
      m_starve = (ic_req_valid && !exp_ic) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      if (exp_ic || exp_dc) begin
        m_busy = 1; m_acc = 0; m_drop = 0;
        m_owner_dc = exp_dc;
        m_addr  = (exp_dc ? dc_req_addr : ic_req_addr) & ~32'hF;
        m_we    = exp_dc && dc_req_we;
        m_wdata = dc_req_wdata;
        if (m_we) ref_mem[m_addr] = dc_req_wdata;
        else m_rdata = ref_mem.exists(m_addr) ? ref_mem[m_addr] : line_init(m_addr);
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clock) begin
    exp_t e;
    if (ic_resp_valid) begin ic_pulses++; last_ic_pulse = cyc; end
    if (dc_resp_valid) begin dc_pulses++; last_dc_pulse = cyc; end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("resp_ic_valid", ic_resp_valid, !e.owner_dc);
      check("resp_dc_valid", dc_resp_valid, e.owner_dc);
      if (e.is_read) check("resp_data", e.owner_dc ? dc_resp_data : ic_resp_data, e.data);
    end else if (ic_resp_valid || dc_resp_valid) begin
      check("resp_spurious", {ic_resp_valid, dc_resp_valid}, 0);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    if (ic_acc) ic_req_valid = 1'b0;
    if (dc_acc) dc_req_valid = 1'b0;
    ic_flush = 1'b0;
  endtask

  task automatic ic_issue(input logic [AW-1:0] a);
    ic_req_valid = 1'b1;
    ic_req_addr  = a;
  endtask

  task automatic dc_issue(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] d);
    dc_req_valid = 1'b1;
    dc_req_we    = we;
    dc_req_addr  = a;
    dc_req_wdata = d;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      done = !m_busy && !ic_req_valid && !dc_req_valid && (exp_q.size() == 0) && !busy;
      if (done) break;
    end
    check("drain", {busy, m_busy, ic_req_valid, dc_req_valid, exp_q.size() != 0}, 0);
  endtask

  initial begin
    int p_ic, p_dc;
    reset = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0; ic_flush = 1'b0;
    dc_req_valid = 1'b0; dc_req_we = 1'b0; dc_req_addr = '0; dc_req_wdata = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Single icache read, zero-wait memory: pulse three cycles after grant.
    force_stall = 0; force_lat = 0;
    p_dc = dc_pulses;
    ic_issue(32'h1004);
    wait_idle(20);
    check("ic_latency", last_ic_pulse - last_ic_grant, 3);
    check("ic_only_no_dc", dc_pulses - p_dc, 0);

    // Simultaneous requests: dcache first.
    ic_issue(32'h2000);
    dc_issue(1'b0, 32'h3008, '0);
    wait_idle(30);
    check("dc_before_ic", last_dc_pulse < last_ic_pulse, 1);

    // Dcache continuously valid: icache must still get through.
    ic_issue(32'h4000);
    for (int i = 0; i < 40 && ic_req_valid; i++) begin
      tick();
      if (!dc_req_valid) dc_issue(1'b0, 32'h4100 + 32'(i * 16), '0);
    end
    check("ic_granted_under_dc", ic_req_valid, 0);
    check("ic_opportunities", last_ic_opp <= LIMIT + 1, 1);
    wait_idle(40);

    // Flush during WAIT of an icache read drops the refill.
    force_lat = 3;
    p_ic = ic_pulses;
    ic_issue(32'h5000);
    for (int i = 0; i < 20 && !(m_busy && m_acc); i++) tick();
    tick();
    ic_flush = 1'b1;
    wait_idle(30);
    check("flush_dropped", ic_pulses - p_ic, 0);
    force_lat = 0;
    ic_issue(32'h5010);
    wait_idle(30);
    check("after_flush_served", ic_pulses - p_ic, 1);

    // Dcache write with a stalled memory port, then read it back.
    force_stall = 3;
    p_dc = dc_pulses;
    dc_issue(1'b1, 32'h6000, {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFEED_F00D});
    wait_idle(30);
    check("write_ack", dc_pulses - p_dc, 1);
    force_stall = 0;
    dc_issue(1'b0, 32'h600C, '0);
    wait_idle(30);

    // Reset while the request sits in ISSUE.
    force_stall = 6;
    ic_issue(32'h7000);
    for (int i = 0; i < 20 && !(m_busy && !m_acc); i++) tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    force_stall = 0;
    p_ic = ic_pulses;
    ic_issue(32'h7010);
    wait_idle(30);
    check("post_reset_served", ic_pulses - p_ic, 1);

    // Random traffic with random memory timing and flushes.
    force_stall = -1; force_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!ic_req_valid && ($urandom_range(0, 3) == 0))
        ic_issue(32'h8000 + 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 15)));
      if (!dc_req_valid && ($urandom_range(0, 3) == 0))
        dc_issue(1'($urandom_range(0, 1)),
                 32'h8000 + 32'($urandom_range(0, 7)) * 16 + 32'($urandom_range(0, 15)),
                 {$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 7) == 0) ic_flush = 1'b1;
    end
    wait_idle(200);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
